// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : RV32I 5-stage main control. Decodes the ID opcode, carries the
//            control bundle through ID/EX, EX/MEM and MEM/WB, inserts
//            load-use bubbles, honours a global freeze and counts retirements.
//            Optional JAL/JALR decode and id_jump_o: define PIPE_CTRL_JUMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               freeze_i,
    input  logic               id_valid_i,
    input  logic [6:0]         id_op_i,
    input  logic [REG_AW-1:0]  id_rs1_i,
    input  logic [REG_AW-1:0]  id_rs2_i,
    input  logic [REG_AW-1:0]  id_rd_i,
    output logic               id_branch_o,
`ifdef PIPE_CTRL_JUMP_EN
    output logic               id_jump_o,
`endif
    output logic               stall_o,
    output logic [ALUOP_W-1:0] ex_alu_op_o,
    output logic               ex_alu_src_o,
    output logic               ex_reg_write_o,
    output logic [REG_AW-1:0]  ex_rd_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               mem_reg_write_o,
    output logic [REG_AW-1:0]  mem_rd_o,
    output logic               wb_reg_write_o,
    output logic               wb_mem_to_reg_o,
    output logic [REG_AW-1:0]  wb_rd_o,
    output logic [CNT_W-1:0]   retire_cnt_o
);

    localparam logic [6:0] c_op_r    = 7'b0110011;
    localparam logic [6:0] c_op_i    = 7'b0010011;
    localparam logic [6:0] c_op_lw   = 7'b0000011;
    localparam logic [6:0] c_op_sw   = 7'b0100011;
    localparam logic [6:0] c_op_beq  = 7'b1100011;
`ifdef PIPE_CTRL_JUMP_EN
    localparam logic [6:0] c_op_jal  = 7'b1101111;
    localparam logic [6:0] c_op_jalr = 7'b1100111;
`endif

    localparam logic [ALUOP_W-1:0] c_aluop_rr  = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] c_aluop_add = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] c_aluop_imm = ALUOP_W'(2'b10);
    localparam logic [ALUOP_W-1:0] c_aluop_br  = ALUOP_W'(2'b11);

    typedef struct packed {
        logic               valid;
        logic               alu_src;
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic [ALUOP_W-1:0] alu_op;
        logic [REG_AW-1:0]  rd;
    } id_ex_t;

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic [REG_AW-1:0]  rd;
    } ex_mem_t;

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_to_reg;
        logic [REG_AW-1:0]  rd;
    } mem_wb_t;

    localparam id_ex_t c_bubble = '0;

    id_ex_t            w_dec;
    logic              w_dec_branch;
    logic              w_uses_rs2;
    logic              w_hit_rs1;
    logic              w_hit_rs2;
`ifdef PIPE_CTRL_JUMP_EN
    logic              w_dec_jump;
`endif

    id_ex_t            r_id_ex;
    ex_mem_t           r_ex_mem;
    mem_wb_t           r_mem_wb;
    logic [CNT_W-1:0]  r_retire_cnt;

    always_comb begin
        w_dec        = c_bubble;
        w_dec_branch = 1'b0;
`ifdef PIPE_CTRL_JUMP_EN
        w_dec_jump   = 1'b0;
`endif
        case (id_op_i)
            c_op_r, c_op_sw, c_op_beq: w_uses_rs2 = 1'b1;
            default:                   w_uses_rs2 = 1'b0;
        endcase

        if (id_valid_i) begin
            case (id_op_i)
                c_op_r: begin
                    w_dec.valid     = 1'b1;
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_op    = c_aluop_rr;
                end
                c_op_i: begin
                    w_dec.valid     = 1'b1;
                    w_dec.alu_src   = 1'b1;
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_op    = c_aluop_imm;
                end
                c_op_lw: begin
                    w_dec.valid      = 1'b1;
                    w_dec.alu_src    = 1'b1;
                    w_dec.reg_write  = 1'b1;
                    w_dec.mem_to_reg = 1'b1;
                    w_dec.mem_read   = 1'b1;
                    w_dec.alu_op     = c_aluop_add;
                end
                c_op_sw: begin
                    w_dec.valid     = 1'b1;
                    w_dec.alu_src   = 1'b1;
                    w_dec.mem_write = 1'b1;
                    w_dec.alu_op    = c_aluop_add;
                end
                c_op_beq: begin
                    w_dec.valid  = 1'b1;
                    w_dec_branch = 1'b1;
                    w_dec.alu_op = c_aluop_br;
                end
`ifdef PIPE_CTRL_JUMP_EN
                c_op_jal: begin
                    w_dec.valid     = 1'b1;
                    w_dec.reg_write = 1'b1;
                    w_dec_jump      = 1'b1;
                end
                c_op_jalr: begin
                    w_dec.valid     = 1'b1;
                    w_dec.alu_src   = 1'b1;
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_op    = c_aluop_add;
                    w_dec_jump      = 1'b1;
                end
`endif
                default: ;
            endcase
            if (w_dec.valid) begin
                w_dec.rd = id_rd_i;
            end
        end

        // x0 is never written, so the write-enable is dropped at decode.
        if (w_dec.rd == '0) begin
            w_dec.reg_write = 1'b0;
        end
    end

    assign w_hit_rs1 = (r_id_ex.rd == id_rs1_i);
    assign w_hit_rs2 = w_uses_rs2 && (r_id_ex.rd == id_rs2_i);

    assign stall_o = r_id_ex.mem_read && r_id_ex.valid && (r_id_ex.rd != '0)
                     && (w_hit_rs1 || w_hit_rs2) && id_valid_i;

    assign id_branch_o = w_dec_branch && !stall_o;
`ifdef PIPE_CTRL_JUMP_EN
    assign id_jump_o   = w_dec_jump && !stall_o;
`endif

    // Freeze outranks the load-use bubble: nothing advances while it is high.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_id_ex      <= c_bubble;
            r_ex_mem     <= '0;
            r_mem_wb     <= '0;
            r_retire_cnt <= '0;
        end else if (!freeze_i) begin
            r_id_ex             <= stall_o ? c_bubble : w_dec;

            r_ex_mem.valid      <= r_id_ex.valid;
            r_ex_mem.reg_write  <= r_id_ex.reg_write;
            r_ex_mem.mem_to_reg <= r_id_ex.mem_to_reg;
            r_ex_mem.mem_read   <= r_id_ex.mem_read;
            r_ex_mem.mem_write  <= r_id_ex.mem_write;
            r_ex_mem.rd         <= r_id_ex.rd;

            r_mem_wb.valid      <= r_ex_mem.valid;
            r_mem_wb.reg_write  <= r_ex_mem.reg_write;
            r_mem_wb.mem_to_reg <= r_ex_mem.mem_to_reg;
            r_mem_wb.rd         <= r_ex_mem.rd;

            if (r_mem_wb.valid) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign ex_alu_op_o     = r_id_ex.alu_op;
    assign ex_alu_src_o    = r_id_ex.alu_src;
    assign ex_reg_write_o  = r_id_ex.reg_write;
    assign ex_rd_o         = r_id_ex.rd;
    assign mem_read_o      = r_ex_mem.mem_read;
    assign mem_write_o     = r_ex_mem.mem_write;
    assign mem_reg_write_o = r_ex_mem.reg_write;
    assign mem_rd_o        = r_ex_mem.rd;
    assign wb_reg_write_o  = r_mem_wb.reg_write;
    assign wb_mem_to_reg_o = r_mem_wb.mem_to_reg;
    assign wb_rd_o         = r_mem_wb.rd;
    assign retire_cnt_o    = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Brief    : Directed self-checking bench for pipe_ctrl_unit, plus a CNT_W=4
//            instance for counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

    localparam logic [6:0] c_op_r    = 7'b0110011;
    localparam logic [6:0] c_op_i    = 7'b0010011;
    localparam logic [6:0] c_op_lw   = 7'b0000011;
    localparam logic [6:0] c_op_sw   = 7'b0100011;
    localparam logic [6:0] c_op_beq  = 7'b1100011;
    localparam logic [6:0] c_op_jal  = 7'b1101111;
    localparam logic [6:0] c_op_jalr = 7'b1100111;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        id_valid;
    logic [6:0]  id_op;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    logic        id_branch, stall;
    logic [1:0]  ex_alu_op;
    logic        ex_alu_src, ex_reg_write;
    logic [4:0]  ex_rd;
    logic        mem_read, mem_write, mem_reg_write;
    logic [4:0]  mem_rd;
    logic        wb_reg_write, wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic [31:0] retire_cnt;

    logic        q_id_branch, q_stall;
    logic [1:0]  q_ex_alu_op;
    logic        q_ex_alu_src, q_ex_reg_write;
    logic [4:0]  q_ex_rd;
    logic        q_mem_read, q_mem_write, q_mem_reg_write;
    logic [4:0]  q_mem_rd;
    logic        q_wb_reg_write, q_wb_mem_to_reg;
    logic [4:0]  q_wb_rd;
    logic [3:0]  q_retire_cnt;
`ifdef PIPE_CTRL_JUMP_EN
    logic        id_jump, q_id_jump;
`endif

    logic [8:0]  ex_v;
    logic [7:0]  mem_v;
    logic [6:0]  wb_v;
    assign ex_v  = {ex_alu_op, ex_alu_src, ex_reg_write, ex_rd};
    assign mem_v = {mem_read, mem_write, mem_reg_write, mem_rd};
    assign wb_v  = {wb_reg_write, wb_mem_to_reg, wb_rd};

    int errors = 0;
    int checks = 0;

    pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(2), .CNT_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .freeze_i(freeze), .id_valid_i(id_valid),
        .id_op_i(id_op), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_branch_o(id_branch),
`ifdef PIPE_CTRL_JUMP_EN
        .id_jump_o(id_jump),
`endif
        .stall_o(stall), .ex_alu_op_o(ex_alu_op), .ex_alu_src_o(ex_alu_src),
        .ex_reg_write_o(ex_reg_write), .ex_rd_o(ex_rd), .mem_read_o(mem_read),
        .mem_write_o(mem_write), .mem_reg_write_o(mem_reg_write), .mem_rd_o(mem_rd),
        .wb_reg_write_o(wb_reg_write), .wb_mem_to_reg_o(wb_mem_to_reg), .wb_rd_o(wb_rd),
        .retire_cnt_o(retire_cnt)
    );

    pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(2), .CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .freeze_i(freeze), .id_valid_i(id_valid),
        .id_op_i(id_op), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_branch_o(q_id_branch),
`ifdef PIPE_CTRL_JUMP_EN
        .id_jump_o(q_id_jump),
`endif
        .stall_o(q_stall), .ex_alu_op_o(q_ex_alu_op), .ex_alu_src_o(q_ex_alu_src),
        .ex_reg_write_o(q_ex_reg_write), .ex_rd_o(q_ex_rd), .mem_read_o(q_mem_read),
        .mem_write_o(q_mem_write), .mem_reg_write_o(q_mem_reg_write), .mem_rd_o(q_mem_rd),
        .wb_reg_write_o(q_wb_reg_write), .wb_mem_to_reg_o(q_wb_mem_to_reg), .wb_rd_o(q_wb_rd),
        .retire_cnt_o(q_retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [6:0] op,
                          input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        id_valid = v;
        id_op    = op;
        id_rs1   = a;
        id_rs2   = b;
        id_rd    = d;
    endtask

    task automatic pulse_reset;
        freeze = 1'b0;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst    = 1'b0;
        freeze = 1'b0;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        #1;
        checks++; if ({ex_v, mem_v, wb_v} !== 24'd0) begin errors++; $display("FAIL reset_stages: got %h exp 000000", {ex_v, mem_v, wb_v}); end
        checks++; if ({retire_cnt, stall, id_branch} !== 34'd0) begin errors++; $display("FAIL reset_cnt: got %h exp 0", {retire_cnt, stall, id_branch}); end
        @(negedge clk);
        rst = 1'b1;
        tick;
        set_id(1'b1, c_op_r,  5'd1, 5'd2, 5'd3); tick;
        set_id(1'b1, c_op_lw, 5'd1, 5'd0, 5'd4); tick;
        set_id(1'b1, c_op_sw, 5'd1, 5'd2, 5'd0); tick;
        set_id(1'b1, c_op_i,  5'd1, 5'd0, 5'd8); tick;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        checks++; if ({ex_v, mem_v, wb_v} !== {2'b10, 1'b1, 1'b1, 5'd8, 8'b0100_0000, 1'b1, 1'b1, 5'd4}) begin errors++; $display("FAIL reset_preload: got %h", {ex_v, mem_v, wb_v}); end
        checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL reset_precnt: got %0d exp 1", retire_cnt); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({ex_v, mem_v, wb_v} !== 24'd0) begin errors++; $display("FAIL reset_async_stages: got %h exp 000000", {ex_v, mem_v, wb_v}); end
        checks++; if ({retire_cnt, stall, id_branch} !== 34'd0) begin errors++; $display("FAIL reset_async_cnt: got %h exp 0", {retire_cnt, stall, id_branch}); end
        @(negedge clk);
        rst = 1'b1;
        tick;
    endtask

    task automatic test_rtype;
        pulse_reset;
        set_id(1'b1, c_op_r, 5'd1, 5'd2, 5'd3);
        #1;
        checks++; if ({stall, id_branch} !== 2'b00) begin errors++; $display("FAIL rtype_comb: got %b exp 00", {stall, id_branch}); end
        tick;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        checks++; if (ex_v !== {2'b00, 1'b0, 1'b1, 5'd3}) begin errors++; $display("FAIL rtype_ex: got %h exp 023", ex_v); end
        tick;
        checks++; if ({ex_v, mem_v} !== {9'd0, 1'b0, 1'b0, 1'b1, 5'd3}) begin errors++; $display("FAIL rtype_mem: got %h exp 00023", {ex_v, mem_v}); end
        tick;
        checks++; if ({wb_v, retire_cnt} !== {1'b1, 1'b0, 5'd3, 32'd0}) begin errors++; $display("FAIL rtype_wb: got %h", {wb_v, retire_cnt}); end
        tick;
        checks++; if ({wb_v, retire_cnt} !== {7'd0, 32'd1}) begin errors++; $display("FAIL rtype_cnt: got %h", {wb_v, retire_cnt}); end
    endtask

    task automatic test_load_use;
        pulse_reset;
        set_id(1'b1, c_op_lw, 5'd1, 5'd0, 5'd5);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_first: got %b exp 0", stall); end
        tick;
        checks++; if (ex_v !== {2'b01, 1'b1, 1'b1, 5'd5}) begin errors++; $display("FAIL lu_lw_ex: got %h", ex_v); end
        set_id(1'b1, c_op_r, 5'd5, 5'd1, 5'd6);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b exp 1", stall); end
        tick;
        checks++; if ({ex_v, mem_v} !== {9'd0, 1'b1, 1'b0, 1'b1, 5'd5}) begin errors++; $display("FAIL lu_bubble: got %h", {ex_v, mem_v}); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_one: got %b exp 0", stall); end
        tick;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        checks++; if (ex_v !== {2'b00, 1'b0, 1'b1, 5'd6}) begin errors++; $display("FAIL lu_add_ex: got %h", ex_v); end
        pulse_reset;
        set_id(1'b1, c_op_lw, 5'd1, 5'd0, 5'd7);
        tick;
        set_id(1'b1, c_op_beq, 5'd1, 5'd7, 5'd0);
        #1;
        checks++; if ({stall, id_branch} !== 2'b10) begin errors++; $display("FAIL lu_beq_rs2: got %b exp 10", {stall, id_branch}); end
        tick;
        checks++; if ({stall, id_branch} !== 2'b01) begin errors++; $display("FAIL lu_beq_go: got %b exp 01", {stall, id_branch}); end
        tick;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        checks++; if (ex_v !== {2'b11, 1'b0, 1'b0, 5'd0}) begin errors++; $display("FAIL lu_beq_ex: got %h", ex_v); end
    endtask

    task automatic test_no_false_stall;
        pulse_reset;
        set_id(1'b1, c_op_lw, 5'd1, 5'd0, 5'd0);
        tick;
        checks++; if (ex_v !== {2'b01, 1'b1, 1'b0, 5'd0}) begin errors++; $display("FAIL nfs_x0_ex: got %h", ex_v); end
        set_id(1'b1, c_op_r, 5'd0, 5'd0, 5'd6);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nfs_x0: got %b exp 0", stall); end
        pulse_reset;
        set_id(1'b1, c_op_lw, 5'd1, 5'd0, 5'd5);
        tick;
        set_id(1'b1, c_op_i, 5'd1, 5'd5, 5'd6);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nfs_itype_rs2: got %b exp 0", stall); end
        set_id(1'b1, c_op_sw, 5'd1, 5'd5, 5'd0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nfs_sw_rs2: got %b exp 1", stall); end
        set_id(1'b0, c_op_r, 5'd5, 5'd5, 5'd6);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nfs_invalid: got %b exp 0", stall); end
        tick;
    endtask

    task automatic test_freeze;
        pulse_reset;
        set_id(1'b1, c_op_r, 5'd1, 5'd2, 5'd3);
        tick;
        set_id(1'b1, c_op_sw, 5'd1, 5'd2, 5'd0);
        tick;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if ({ex_v, mem_v, wb_v, retire_cnt} !== {2'b01, 1'b1, 1'b0, 5'd0, 8'b0010_0011, 7'd0, 32'd0}) begin errors++; $display("FAIL freeze_hold%0d: got %h", k, {ex_v, mem_v, wb_v, retire_cnt}); end
        end
        freeze = 1'b0;
        tick;
        checks++; if ({ex_v, mem_v, wb_v} !== {9'd0, 8'b0100_0000, 1'b1, 1'b0, 5'd3}) begin errors++; $display("FAIL freeze_release: got %h", {ex_v, mem_v, wb_v}); end
        tick;
        checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL freeze_cnt: got %0d exp 1", retire_cnt); end
    endtask

    task automatic test_unknown;
        pulse_reset;
        set_id(1'b1, 7'b0000000, 5'd1, 5'd2, 5'd3);
        #1;
        checks++; if ({stall, id_branch} !== 2'b00) begin errors++; $display("FAIL unk_comb: got %b exp 00", {stall, id_branch}); end
        tick;
        set_id(1'b0, c_op_r, 5'd1, 5'd2, 5'd3);
        checks++; if (ex_v !== 9'd0) begin errors++; $display("FAIL unk_ex: got %h exp 000", ex_v); end
        tick;
`ifdef PIPE_CTRL_JUMP_EN
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
`else
        set_id(1'b1, c_op_jal, 5'd1, 5'd2, 5'd3);
`endif
        checks++; if ({ex_v, mem_v} !== 17'd0) begin errors++; $display("FAIL unk_invalid: got %h exp 0", {ex_v, mem_v}); end
        tick;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        checks++; if (ex_v !== 9'd0) begin errors++; $display("FAIL unk_jal: got %h exp 000", ex_v); end
        tick;
        tick;
        checks++; if ({wb_v, retire_cnt} !== 39'd0) begin errors++; $display("FAIL unk_cnt: got %h exp 0", {wb_v, retire_cnt}); end
    endtask

`ifdef PIPE_CTRL_JUMP_EN
    task automatic test_jump;
        pulse_reset;
        set_id(1'b1, c_op_lw, 5'd1, 5'd0, 5'd9);
        tick;
        set_id(1'b1, c_op_jalr, 5'd2, 5'd9, 5'd1);
        #1;
        checks++; if ({stall, id_jump} !== 2'b01) begin errors++; $display("FAIL jalr_comb: got %b exp 01", {stall, id_jump}); end
        tick;
        set_id(1'b1, c_op_jal, 5'd9, 5'd9, 5'd1);
        checks++; if (ex_v !== {2'b01, 1'b1, 1'b1, 5'd1}) begin errors++; $display("FAIL jalr_ex: got %h", ex_v); end
        tick;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        checks++; if (ex_v !== {2'b00, 1'b0, 1'b1, 5'd1}) begin errors++; $display("FAIL jal_ex: got %h", ex_v); end
    endtask
`endif

    task automatic test_wrap;
        pulse_reset;
        set_id(1'b1, c_op_r, 5'd1, 5'd2, 5'd3);
        repeat (17) tick;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick;
        tick;
        checks++; if ({q_retire_cnt, retire_cnt} !== {4'd0, 32'd16}) begin errors++; $display("FAIL wrap_16: got %0d/%0d exp 0/16", q_retire_cnt, retire_cnt); end
        tick;
        checks++; if ({q_retire_cnt, retire_cnt} !== {4'd1, 32'd17}) begin errors++; $display("FAIL wrap_17: got %0d/%0d exp 1/17", q_retire_cnt, retire_cnt); end
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_load_use;
        test_no_false_stall;
        test_freeze;
        test_unknown;
`ifdef PIPE_CTRL_JUMP_EN
        test_jump;
`endif
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
